// File: rtl/fifo_if.sv
// Producer/consumer handshake bundle for the single-clock FWFT FIFO.
// The producer/consumer side takes the master modport; the FIFO takes the slave modport.
interface fifo_if #(
  parameter int DSIZE = 8
);
  logic [DSIZE-1:0] wdata;
  logic             winc;
  logic             wfull;
  logic [DSIZE-1:0] rdata;
  logic             rinc;
  logic             rempty;

  modport master (
    output wdata, winc, rinc,
    input  wfull, rdata, rempty
  );

  modport slave (
    input  wdata, winc, rinc,
    output wfull, rdata, rempty
  );
endinterface

// File: rtl/fifo.sv
// Single-clock first-word-fall-through FIFO, 2**ASIZE entries of DSIZE bits.
// Wrap-bit pointers tell full from empty; requests that would overflow or underflow are dropped.
module fifo #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 3
) (
  input  logic  clk,
  input  logic  rst_n,
  fifo_if.slave bus
);
  localparam int DEPTH = 1 << ASIZE;

  logic [ASIZE:0]   wptr_r;
  logic [ASIZE:0]   rptr_r;
  logic [DSIZE-1:0] mem_r [DEPTH];
  logic             empty_s;
  logic             full_s;
  logic             wr_en_s;
  logic             rd_en_s;

  // Flags come straight from the registered pointers, so they match the pointers in the same cycle.
  always_comb begin
    empty_s = 1'b0;
    full_s  = 1'b0;
    wr_en_s = 1'b0;
    rd_en_s = 1'b0;
    if (wptr_r == rptr_r) begin
      empty_s = 1'b1;
    end else begin
      empty_s = 1'b0;
    end
    if ((wptr_r[ASIZE] != rptr_r[ASIZE]) &&
        (wptr_r[ASIZE-1:0] == rptr_r[ASIZE-1:0])) begin
      full_s = 1'b1;
    end else begin
      full_s = 1'b0;
    end
    wr_en_s = bus.winc && !full_s;
    rd_en_s = bus.rinc && !empty_s;
  end

  assign bus.wfull  = full_s;
  assign bus.rempty = empty_s;
  assign bus.rdata  = mem_r[rptr_r[ASIZE-1:0]];

  // Pointer update; reset discards stored words by realigning both pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r <= {(ASIZE+1){1'b0}};
      rptr_r <= {(ASIZE+1){1'b0}};
    end else begin
      if (wr_en_s) begin
        wptr_r <= wptr_r + {{ASIZE{1'b0}}, 1'b1};
      end else begin
        wptr_r <= wptr_r;
      end
      if (rd_en_s) begin
        rptr_r <= rptr_r + {{ASIZE{1'b0}}, 1'b1};
      end else begin
        rptr_r <= rptr_r;
      end
    end
  end

  // Storage array is intentionally left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wptr_r[ASIZE-1:0]] <= bus.wdata;
    end
  end
endmodule

// File: tb/tb_fifo.sv
// Randomised and directed bench for the FWFT FIFO, checked every cycle against a queue model.
module tb_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fifo_if #(.DSIZE(8)) bus ();
  fifo #(.DSIZE(8), .ASIZE(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] model_q [$];
  logic [7:0] popped [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a queue of at most 8 words; flags are judged on the occupancy before the edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_q.delete();
    end else begin
      bit rd;
      bit wr;
      rd = bus.rinc && (model_q.size() > 0);
      wr = bus.winc && (model_q.size() < 8);
      if (rd) popped.push_back(model_q.pop_front());
      if (wr) model_q.push_back(bus.wdata);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("rempty", 32'(bus.rempty), 32'(model_q.size() == 0));
      check("wfull", 32'(bus.wfull), 32'(model_q.size() == 8));
      if (model_q.size() > 0) check("rdata", 32'(bus.rdata), 32'(model_q[0]));
    end
  end

  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    bus.winc  = w;
    bus.wdata = d;
    bus.rinc  = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wrote;
    int budget;
    bus.winc = 1'b0;
    bus.rinc = 1'b0;
    bus.wdata = 8'h00;
    rst_n = 1'b0;

    // 1. reset
    repeat (2) @(posedge clk);
    #1;
    check("reset_rempty", 32'(bus.rempty), 32'd1);
    check("reset_wfull", 32'(bus.wfull), 32'd0);
    rst_n = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    check("idle_rempty", 32'(bus.rempty), 32'd1);
    check("idle_wfull", 32'(bus.wfull), 32'd0);

    // 2. fill and drain
    popped.delete();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 8'(8'hA0 + i), 1'b0);
      if (i == 0) check("first_write_rempty", 32'(bus.rempty), 32'd0);
    end
    check("fill_wfull", 32'(bus.wfull), 32'd1);
    for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1);
    check("drain_rempty", 32'(bus.rempty), 32'd1);
    check("drain_count", 32'(popped.size()), 32'd8);
    for (int i = 0; i < 8; i++) check("drain_order", 32'(popped[i]), 32'(8'hA0 + i));

    // 3. overflow
    popped.delete();
    for (int i = 0; i < 11; i++) cyc(1'b1, 8'(8'hB0 + i), 1'b0);
    check("ovf_wfull", 32'(bus.wfull), 32'd1);
    check("ovf_head", 32'(bus.rdata), 32'hB0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1);
    check("ovf_rempty", 32'(bus.rempty), 32'd1);
    check("ovf_count", 32'(popped.size()), 32'd8);
    for (int i = 0; i < 8; i++) check("ovf_order", 32'(popped[i]), 32'(8'hB0 + i));

    // 4. underflow
    popped.delete();
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0);
    for (int i = 0; i < 11; i++) cyc(1'b0, 8'h00, 1'b1);
    check("unf_rempty", 32'(bus.rempty), 32'd1);
    check("unf_count", 32'(popped.size()), 32'd8);
    check("unf_last", 32'(popped[7]), 32'hC7);
    cyc(1'b1, 8'h5A, 1'b0);
    check("unf_rdata_5a", 32'(bus.rdata), 32'h5A);
    check("unf_not_empty", 32'(bus.rempty), 32'd0);
    cyc(1'b0, 8'h00, 1'b1);

    // 5. simultaneous read and write
    popped.delete();
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'hD0 + i), 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'hE0 + i), 1'b1);
    check("sim_count", 32'(model_q.size()), 32'd3);
    check("sim_head", 32'(bus.rdata), 32'hE2);
    check("sim_pop0", 32'(popped[0]), 32'hD0);
    check("sim_pop4", 32'(popped[4]), 32'hE1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1);
    popped.delete();
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'hF0 + i), 1'b0);
    cyc(1'b1, 8'h99, 1'b1);
    check("full_rw_wfull", 32'(bus.wfull), 32'd0);
    check("full_rw_count", 32'(model_q.size()), 32'd7);
    check("full_rw_head", 32'(bus.rdata), 32'hF1);
    for (int i = 0; i < 7; i++) cyc(1'b0, 8'h00, 1'b1);
    check("full_rw_popped", 32'(popped.size()), 32'd8);
    check("full_rw_tail", 32'(popped[7]), 32'hF7);
    check("full_rw_rempty", 32'(bus.rempty), 32'd1);
    cyc(1'b1, 8'h77, 1'b1);
    check("empty_rw_rempty", 32'(bus.rempty), 32'd0);
    check("empty_rw_rdata", 32'(bus.rdata), 32'h77);
    cyc(1'b0, 8'h00, 1'b1);

    // 6. random traffic, then reset mid-stream
    wrote = 0;
    budget = 0;
    while (wrote < 20 && budget < 300) begin
      logic w;
      logic r;
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 2) == 0);
      if (w && model_q.size() < 8) wrote++;
      cyc(w, 8'($urandom), r);
      budget++;
    end
    check("rand_budget", 32'(wrote >= 20), 32'd1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'($urandom), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_rempty", 32'(bus.rempty), 32'd1);
    check("midrst_wfull", 32'(bus.wfull), 32'd0);
    check("midrst_model", 32'(model_q.size()), 32'd0);
    bus.winc = 1'b0;
    bus.rinc = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b1, 8'h3C, 1'b0);
    cyc(1'b1, 8'hC3, 1'b0);
    check("post_rst_rdata0", 32'(bus.rdata), 32'h3C);
    cyc(1'b0, 8'h00, 1'b1);
    check("post_rst_rdata1", 32'(bus.rdata), 32'hC3);
    cyc(1'b0, 8'h00, 1'b1);
    check("post_rst_rempty", 32'(bus.rempty), 32'd1);
    cyc(1'b0, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
